// File: rtl/pipeline_register_wb_skid.sv
// -----------------------------------------------------------------------------
// pipeline_register_wb_skid
//
// Two-entry skid buffer sitting between the MEM/EX stage and write-back.
// The head entry drives the *_WB outputs; the skid entry catches a beat that
// arrives while the head is stalled. ready_MEMEX comes straight from a
// register (NOT skid.valid), so there is no combinational path from ready_WB
// back to the upstream stage.
//
// Parameters
//   XLEN        result data width
//   RADDR_W     destination-register index width
//   SUPPRESS_X0 when non-zero, beats targeting rd==0 never request a write
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             drop every held entry (and any beat accepted this cycle)
//   valid_MEMEX       upstream beat valid
//   ready_MEMEX       buffer can accept a beat this cycle (registered)
//   invalid_MEMEX     beat is a killed bubble: occupies a slot, never writes
//   rd_MEMEX          beat destination register
//   alu_result_MEMEX  beat result
//   regfile_we_MEMEX  beat requests a register write
//   valid_WB          head entry valid
//   ready_WB          downstream consumes the head entry
//   rd_WB             head destination register
//   alu_result_WB     head result
//   regfile_we_WB     head write enable, gated by valid_WB
//   fwd_valid         head is an active forwarding source
//   count             entries held (0..2)
// -----------------------------------------------------------------------------
module pipeline_register_wb_skid #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 4,
    parameter int SUPPRESS_X0 = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,

    input  logic               valid_MEMEX,
    output logic               ready_MEMEX,
    input  logic               invalid_MEMEX,
    input  logic [RADDR_W-1:0] rd_MEMEX,
    input  logic [XLEN-1:0]    alu_result_MEMEX,
    input  logic               regfile_we_MEMEX,

    output logic               valid_WB,
    input  logic               ready_WB,
    output logic [RADDR_W-1:0] rd_WB,
    output logic [XLEN-1:0]    alu_result_WB,
    output logic               regfile_we_WB,
    output logic               fwd_valid,
    output logic [1:0]         count
);

    // Head entry
    logic               r_head_valid;
    logic [RADDR_W-1:0] r_head_rd;
    logic [XLEN-1:0]    r_head_result;
    logic               r_head_we;

    // Skid entry
    logic               r_skid_valid;
    logic [RADDR_W-1:0] r_skid_rd;
    logic [XLEN-1:0]    r_skid_result;
    logic               r_skid_we;

    // Handshake and beat qualification
    logic               w_accept;
    logic               w_pop;
    logic               w_is_x0;
    logic               w_beat_we;

    assign w_accept  = valid_MEMEX & ~r_skid_valid;
    assign w_pop     = r_head_valid & ready_WB;

    // A killed beat or a write to x0 still travels through the buffer so the
    // downstream sees it, but it must never reach the register file.
    assign w_is_x0   = (SUPPRESS_X0 != 0) && (rd_MEMEX == '0);
    assign w_beat_we = regfile_we_MEMEX & ~invalid_MEMEX & ~w_is_x0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_valid  <= 1'b0;
            r_head_rd     <= '0;
            r_head_result <= '0;
            r_head_we     <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_rd     <= '0;
            r_skid_result <= '0;
            r_skid_we     <= 1'b0;
        end else if (flush) begin
            // Payload is left in place; only the valid bits matter.
            r_head_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_valid) begin
                // Skid full means ready_MEMEX is low, so no accept can coincide.
                r_head_valid  <= 1'b1;
                r_head_rd     <= r_skid_rd;
                r_head_result <= r_skid_result;
                r_head_we     <= r_skid_we;
                r_skid_valid  <= 1'b0;
            end else if (w_accept) begin
                r_head_valid  <= 1'b1;
                r_head_rd     <= rd_MEMEX;
                r_head_result <= alu_result_MEMEX;
                r_head_we     <= w_beat_we;
            end else begin
                r_head_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_head_valid) begin
                // Head stalled: park the beat in the skid slot.
                r_skid_valid  <= 1'b1;
                r_skid_rd     <= rd_MEMEX;
                r_skid_result <= alu_result_MEMEX;
                r_skid_we     <= w_beat_we;
            end else begin
                r_head_valid  <= 1'b1;
                r_head_rd     <= rd_MEMEX;
                r_head_result <= alu_result_MEMEX;
                r_head_we     <= w_beat_we;
            end
        end
    end

    assign ready_MEMEX   = ~r_skid_valid;
    assign valid_WB      = r_head_valid;
    assign rd_WB         = r_head_rd;
    assign alu_result_WB = r_head_result;
    assign regfile_we_WB = r_head_valid & r_head_we;
    assign fwd_valid     = r_head_valid & r_head_we;
    assign count         = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule

// File: doc/pipeline_register_wb_skid.md
PIPELINE_REGISTER_WB_SKID -- requirements
Module: pipeline_register_wb_skid

Interface
REQ-001 SHALL have parameter XLEN, default 32, result data width in bits.
REQ-002 SHALL have parameter RADDR_W, default 4, destination-register index width (16-entry RV32E file).
REQ-003 SHALL have parameter SUPPRESS_X0, default 1; when 1, writes to rd==0 are converted to no-write.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all held entries.
REQ-007 SHALL have port valid_MEMEX  input  1  upstream beat valid.
REQ-008 SHALL have port ready_MEMEX  output  1  buffer can accept a beat this cycle.
REQ-009 SHALL have port invalid_MEMEX  input  1  beat is a killed (bubble) instruction.
REQ-010 SHALL have port rd_MEMEX  input  RADDR_W  destination register of beat.
REQ-011 SHALL have port alu_result_MEMEX  input  XLEN  result of beat.
REQ-012 SHALL have port regfile_we_MEMEX  input  1  beat requests register write.
REQ-013 SHALL have port valid_WB  output  1  head entry valid.
REQ-014 SHALL have port ready_WB  input  1  downstream consumes head entry.
REQ-015 SHALL have port rd_WB  output  RADDR_W  head destination register.
REQ-016 SHALL have port alu_result_WB  output  XLEN  head result.
REQ-017 SHALL have port regfile_we_WB  output  1  head write enable, gated by valid_WB.
REQ-018 SHALL have port fwd_valid  output  1  forwarding source active (valid_WB & regfile_we_WB).
REQ-019 SHALL have port count  output  2  entries held, 0..2.

Function
REQ-020 SHALL hold two entries: head (drives *_WB outputs) and skid; each entry holds valid, rd, result, we.
REQ-021 SHALL drive ready_MEMEX from a register, equal to NOT skid.valid; no combinational path from ready_WB.
REQ-022 SHALL accept a beat when valid_MEMEX & ready_MEMEX; pop the head when valid_WB & ready_WB.
REQ-023 SHALL store we = regfile_we_MEMEX & ~invalid_MEMEX & ~(SUPPRESS_X0 & rd_MEMEX==0) on accept; invalid beats still occupy a slot and still pop.
REQ-024 SHALL, accept with head empty or popping and skid empty: beat enters head next cycle (latency 1).
REQ-025 SHALL, accept with head full and not popping: beat enters skid; ready_MEMEX low next cycle.
REQ-026 SHALL, pop with skid full: skid moves to head, skid cleared; ready_MEMEX high next cycle.
REQ-027 SHALL, pop with no accept and skid empty: head.valid cleared next cycle.
REQ-028 SHALL preserve FIFO order; no beat dropped or duplicated except via flush/rst.
REQ-029 SHALL keep head contents stable while valid_WB & ~ready_WB.
REQ-030 SHALL drive regfile_we_WB = head.valid & head.we; fwd_valid = regfile_we_WB.
REQ-031 SHALL drive count = head.valid + skid.valid.
REQ-032 SHALL, on flush, clear both valid bits next cycle, dropping any beat accepted that cycle; flush overrides accept and pop; rd/result contents unspecified.
REQ-033 SHALL leave outputs independent of rd/result/we contents when valid_WB=0, except rd_WB/alu_result_WB may show stale data.

Reset
REQ-034 SHALL, when rst=1 at a clk edge, clear head and skid (valid, we, rd, result all 0).
REQ-035 SHALL after reset present valid_WB=0, regfile_we_WB=0, fwd_valid=0, count=0, ready_MEMEX=1, rd_WB=0, alu_result_WB=0.
REQ-036 SHALL give rst priority over flush, accept and pop, including reset mid-stall with count=2.

Verification
REQ-037 Single beat: rd=5, result=0x1234_5678, we=1, ready_WB=1 -> next cycle valid_WB=1, rd_WB=5, alu_result_WB=0x12345678, regfile_we_WB=1, fwd_valid=1.
REQ-038 Killed/x0: beat rd=3 we=1 invalid=1, then rd=0 we=1 invalid=0 -> both appear with valid_WB=1, regfile_we_WB=0.
REQ-039 Backpressure: ready_WB=0, send A(result=1), B(result=2) -> count=2, ready_MEMEX=0, head A held; ready_WB=1 -> A then B on consecutive cycles, ready_MEMEX=1 after A pops.
REQ-040 Streaming: ready_WB=1, 8 back-to-back beats results 1..8 -> outputs 1..8 on consecutive cycles, ready_MEMEX never low.
REQ-041 Flush: count=2 with a beat offered, flush=1 -> next cycle count=0, valid_WB=0, ready_MEMEX=1, offered beat never emerges.
REQ-042 Reset mid-operation: count=2, rst=1 -> next cycle all outputs per REQ-035.
